// File: rtl/cache_bus_arbiter.sv
// Shares one AXI-style master port between the I-cache and D-cache.
// Reads (line refills) are arbitrated round-robin; D-cache write-backs use
// the write channels concurrently. A D-cache refill that targets the line
// currently being written back is held off until the write response lands.
module cache_bus_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_waddr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_wvalid,
  input  logic              dc_wlast,
  output logic              dc_wready,
  output logic              dc_bvalid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              axi_rvalid,
  input  logic              axi_rlast,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic              axi_wvalid,
  output logic              axi_wlast,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  localparam int                LINE_BYTES = LINE_WORDS * DATA_W / 8;
  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(LINE_BYTES - 1);
  localparam logic [7:0]        BURST_LEN  = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~OFF_MASK;
  endfunction

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  // gnt_dc is both the current burst owner and the round-robin pointer:
  // the requester granted last is always the one that owns the bus.
  logic              gnt_dc;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_done;
  logic              raw_hazard;
  logic              dc_elig;
  logic              pick_dc;
  logic              grant;

  // The hazard window closes in the response cycle so the held refill can
  // be granted while dc_bvalid is pulsing.
  assign wb_done    = (w_state == W_RESP) && axi_bvalid;
  assign raw_hazard = (w_state != W_IDLE) && !wb_done &&
                      (line_base(dc_addr) == wb_addr);
  assign dc_elig    = dc_req && !raw_hazard;
  assign pick_dc    = dc_elig && (!ic_req || !gnt_dc);
  assign grant      = (r_state == R_IDLE) && (ic_req || dc_elig);

  // Read FSM state and grant owner; reset favours the D-cache.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      gnt_dc  <= 1'b0;
    end else begin
      r_state <= r_next;
      if (grant) gnt_dc <= pick_dc;
    end
  end

  // Latch the aligned refill address of the winning requester.
  always_ff @(posedge clock) begin
    if (grant) rd_addr <= pick_dc ? line_base(dc_addr) : line_base(ic_addr);
  end

  // Read FSM next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ic_req || dc_elig) r_next = R_AR;
      R_AR:    if (axi_arready) r_next = R_DATA;
      R_DATA:  if (axi_rvalid && axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read outputs: address phase, then beats steered to the owner only.
  always_comb begin
    ic_rdata    = '0;
    ic_rvalid   = 1'b0;
    dc_rdata    = '0;
    dc_rvalid   = 1'b0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    case (r_state)
      R_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = rd_addr;
        axi_arlen   = BURST_LEN;
      end
      R_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          if (gnt_dc) begin
            dc_rvalid = 1'b1;
            dc_rdata  = axi_rdata;
          end else begin
            ic_rvalid = 1'b1;
            ic_rdata  = axi_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  // Latch the aligned write-back address when a write-back starts.
  always_ff @(posedge clock) begin
    if ((w_state == W_IDLE) && dc_wb) wb_addr <= line_base(dc_waddr);
  end

  // Write FSM next-state logic.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (dc_wb) w_next = W_AW;
      W_AW:   if (axi_awready) w_next = W_DATA;
      W_DATA: if (dc_wvalid && axi_wready && dc_wlast) w_next = W_RESP;
      W_RESP: if (axi_bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write outputs: address phase, beat pass-through, response handshake.
  always_comb begin
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wvalid  = 1'b0;
    axi_wlast   = 1'b0;
    dc_wready   = 1'b0;
    axi_bready  = 1'b0;
    dc_bvalid   = 1'b0;
    case (w_state)
      W_AW: begin
        axi_awvalid = 1'b1;
        axi_awaddr  = wb_addr;
        axi_awlen   = BURST_LEN;
      end
      W_DATA: begin
        axi_wdata  = dc_wdata;
        axi_wvalid = dc_wvalid;
        axi_wlast  = dc_wlast;
        dc_wready  = axi_wready;
      end
      W_RESP: begin
        axi_bready = 1'b1;
        dc_bvalid  = axi_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: the bench plays both caches and
// the AXI slave, and predicts grants with a round-robin model.
module tb_cache_bus_arbiter;

  localparam int LW = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LINE_SHIFT = $clog2(LW * DW / 8);

  logic          clock, reset;
  logic          ic_req, dc_req, dc_wb, dc_wvalid, dc_wlast;
  logic [AW-1:0] ic_addr, dc_addr, dc_waddr;
  logic [DW-1:0] dc_wdata, axi_rdata;
  logic          axi_arready, axi_rvalid, axi_rlast, axi_awready, axi_wready, axi_bvalid;
  logic [DW-1:0] ic_rdata, dc_rdata, axi_wdata;
  logic          ic_rvalid, dc_rvalid, dc_wready, dc_bvalid;
  logic [AW-1:0] axi_araddr, axi_awaddr;
  logic [7:0]    axi_arlen, axi_awlen;
  logic          axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready;

  int            checks;
  int            errors;
  bit            exp_last_dc;
  logic [DW-1:0] wbeat [LW];

  cache_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
    .dc_wb(dc_wb), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata), .dc_wvalid(dc_wvalid),
    .dc_wlast(dc_wlast), .dc_wready(dc_wready), .dc_bvalid(dc_bvalid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid),
    .axi_wlast(axi_wlast), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return (a >> LINE_SHIFT) << LINE_SHIFT;
  endfunction

  // Round-robin rule: lone eligible requester wins; with both, the one
  // not granted last wins.
  function automatic bit model_pick(input bit ic, input bit dc_ok);
    if (ic && dc_ok) return !exp_last_dc;
    return dc_ok;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_rd"}, 64'(|{ic_rdata, ic_rvalid, dc_rdata, dc_rvalid, axi_araddr,
                            axi_arlen, axi_arvalid, axi_rready}), 64'(0));
    chk({tag, "_wr"}, 64'(|{dc_wready, dc_bvalid, axi_awaddr, axi_awlen, axi_awvalid,
                            axi_wdata, axi_wvalid, axi_wlast, axi_bready}), 64'(0));
  endtask

  task automatic clear_inputs();
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_addr = '0;
    dc_wb = 0; dc_waddr = '0; dc_wdata = '0; dc_wvalid = 0; dc_wlast = 0;
    axi_arready = 0; axi_rdata = '0; axi_rvalid = 0; axi_rlast = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) tick();
    settle();
    check_zero("reset_outputs");
    reset = 0;
    exp_last_dc = 0;
  endtask

  task automatic read_burst(input bit exp_dc, input logic [AW-1:0] exp_addr, input int ar_delay,
                            input int drop_at, input int abort_at, output int waited);
    int n;
    logic [DW-1:0] d;
    n = 0;
    while (!axi_arvalid && n < 20) begin
      tick();
      settle();
      n++;
    end
    waited = n;
    chk("ar_seen", 64'(axi_arvalid), 64'(1));
    chk("araddr", 64'(axi_araddr), 64'(exp_addr));
    chk("arlen", 64'(axi_arlen), 64'(LW - 1));
    for (int i = 0; i < ar_delay; i++) begin
      tick();
      settle();
      chk("ar_hold", 64'(axi_arvalid), 64'(1));
      chk("ar_stable", 64'(axi_araddr), 64'(exp_addr));
    end
    axi_arready = 1;
    tick();
    axi_arready = 0;
    settle();
    chk("ar_done", 64'(axi_arvalid), 64'(0));
    chk("rready", 64'(axi_rready), 64'(1));
    for (int b = 0; b < LW; b++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
        axi_rvalid = 0;
        axi_rlast = 0;
        settle();
        chk("gap_ic_rvalid", 64'(ic_rvalid), 64'(0));
        chk("gap_dc_rvalid", 64'(dc_rvalid), 64'(0));
        tick();
      end
      d = $urandom;
      axi_rvalid = 1;
      axi_rdata = d;
      axi_rlast = (b == LW - 1);
      if (b == drop_at) begin
        if (exp_dc) dc_req = 0;
        else ic_req = 0;
      end
      settle();
      if (exp_dc) begin
        chk("dc_rvalid", 64'(dc_rvalid), 64'(1));
        chk("dc_rdata", 64'(dc_rdata), 64'(d));
        chk("ic_rvalid_quiet", 64'(ic_rvalid), 64'(0));
      end else begin
        chk("ic_rvalid", 64'(ic_rvalid), 64'(1));
        chk("ic_rdata", 64'(ic_rdata), 64'(d));
        chk("dc_rvalid_quiet", 64'(dc_rvalid), 64'(0));
      end
      if (b == abort_at) return;
      tick();
    end
    axi_rvalid = 0;
    axi_rlast = 0;
    axi_rdata = '0;
    if (exp_dc) dc_req = 0;
    else ic_req = 0;
    settle();
    chk("r_idle_rready", 64'(axi_rready), 64'(0));
  endtask

  task automatic serve(input int drop_at);
    bit p;
    int w;
    p = model_pick(ic_req, dc_req);
    exp_last_dc = p;
    read_burst(p, line_of(p ? dc_addr : ic_addr), $urandom_range(0, 2), drop_at, -1, w);
    chk("grant_latency", 64'(w), 64'(1));
  endtask

  // mode 0: wready toggles every cycle, wvalid always set; mode 1: random.
  task automatic write_burst(input logic [AW-1:0] addr, input int mode, input bit started);
    int acc;
    bit tog;
    for (int i = 0; i < LW; i++) wbeat[i] = $urandom;
    if (!started) begin
      dc_wb = 1;
      dc_waddr = addr;
      settle();
      tick();
      dc_wb = 0;
    end
    settle();
    chk("awvalid", 64'(axi_awvalid), 64'(1));
    chk("awaddr", 64'(axi_awaddr), 64'(line_of(addr)));
    chk("awlen", 64'(axi_awlen), 64'(LW - 1));
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      tick();
      settle();
      chk("aw_hold", 64'(axi_awvalid), 64'(1));
    end
    axi_awready = 1;
    tick();
    axi_awready = 0;
    acc = 0;
    tog = 1;
    for (int c = 0; c < 64 && acc < LW; c++) begin
      dc_wvalid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      dc_wdata = wbeat[acc];
      dc_wlast = (acc == LW - 1);
      axi_wready = (mode == 0) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      settle();
      chk("aw_dropped", 64'(axi_awvalid), 64'(0));
      chk("wvalid_pass", 64'(axi_wvalid), 64'(dc_wvalid));
      chk("wdata_pass", 64'(axi_wdata), 64'(wbeat[acc]));
      chk("wlast_pass", 64'(axi_wlast), 64'(acc == LW - 1));
      chk("wready_pass", 64'(dc_wready), 64'(axi_wready));
      if (dc_wvalid && axi_wready) acc++;
      tick();
    end
    chk("w_accept_count", 64'(acc), 64'(LW));
    dc_wvalid = 1;
    dc_wlast = 1;
    axi_wready = 1;
    settle();
    chk("resp_wvalid_gated", 64'(axi_wvalid), 64'(0));
    chk("resp_wlast_gated", 64'(axi_wlast), 64'(0));
    chk("resp_wready_gated", 64'(dc_wready), 64'(0));
    chk("resp_bready", 64'(axi_bready), 64'(1));
    dc_wvalid = 0;
    dc_wlast = 0;
    axi_wready = 0;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      tick();
      settle();
      chk("bvalid_early", 64'(dc_bvalid), 64'(0));
      chk("bready_wait", 64'(axi_bready), 64'(1));
    end
    tick();
    axi_bvalid = 1;
    dc_wb = 1;
    settle();
    chk("dc_bvalid_pulse", 64'(dc_bvalid), 64'(1));
    tick();
    axi_bvalid = 0;
    dc_wb = 0;
    settle();
    chk("dc_bvalid_end", 64'(dc_bvalid), 64'(0));
    chk("bready_end", 64'(axi_bready), 64'(0));
    tick();
    settle();
    chk("wb_ignored_on_b", 64'(axi_awvalid), 64'(0));
  endtask

  initial begin
    int w;
    logic [AW-1:0] a;
    checks = 0;
    errors = 0;
    clear_inputs();
    do_reset();

    // Single I-cache miss with arready after two cycles.
    ic_req = 1;
    ic_addr = 32'h1000_0014;
    exp_last_dc = model_pick(1, 0);
    read_burst(0, 32'h1000_0000, 2, -1, -1, w);
    chk("imiss_latency", 64'(w), 64'(1));

    // Simultaneous pair right after reset, then randomized rounds.
    do_reset();
    ic_req = 1; ic_addr = $urandom;
    dc_req = 1; dc_addr = $urandom;
    serve(-1);
    serve(-1);
    for (int r = 0; r < 10; r++) begin
      if (!ic_req && $urandom_range(0, 1) == 1) begin ic_req = 1; ic_addr = $urandom; end
      if (!dc_req && $urandom_range(0, 1) == 1) begin dc_req = 1; dc_addr = $urandom; end
      if (!ic_req && !dc_req) begin ic_req = 1; ic_addr = $urandom; end
      serve((r == 3) ? 2 : -1);
    end
    for (int k = 0; k < 2 && (ic_req || dc_req); k++) serve(-1);

    // Write-backs: toggling wready, then randomized handshakes.
    write_burst(32'h2000_0040, 0, 0);
    for (int k = 0; k < 3; k++) write_burst($urandom, 1, 0);

    // RAW hazard: refill to the line being written back waits for B.
    dc_wb = 1;
    dc_waddr = 32'h2000_0040;
    settle();
    tick();
    dc_wb = 0;
    axi_awready = 1;
    settle();
    chk("raw_awvalid", 64'(axi_awvalid), 64'(1));
    tick();
    axi_awready = 0;
    for (int b = 0; b < LW; b++) begin
      dc_wvalid = 1;
      dc_wdata = $urandom;
      dc_wlast = (b == LW - 1);
      axi_wready = 1;
      if (b == 3) begin dc_req = 1; dc_addr = 32'h2000_005C; end
      settle();
      chk("raw_hold_data", 64'(axi_arvalid), 64'(0));
      tick();
    end
    dc_wvalid = 0;
    dc_wlast = 0;
    axi_wready = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("raw_hold_resp", 64'(axi_arvalid), 64'(0));
      tick();
    end
    axi_bvalid = 1;
    settle();
    chk("raw_bvalid", 64'(dc_bvalid), 64'(1));
    chk("raw_hold_bcycle", 64'(axi_arvalid), 64'(0));
    exp_last_dc = model_pick(ic_req, dc_req);
    tick();
    axi_bvalid = 0;
    settle();
    read_burst(1, 32'h2000_0040, 0, -1, -1, w);
    chk("raw_release_cycle", 64'(w), 64'(0));

    // No hazard: different lines, read and write address phases overlap.
    dc_wb = 1;
    dc_waddr = 32'h2000_0040;
    dc_req = 1;
    dc_addr = 32'h3000_0000;
    exp_last_dc = model_pick(ic_req, dc_req);
    settle();
    tick();
    dc_wb = 0;
    settle();
    chk("overlap_arvalid", 64'(axi_arvalid), 64'(1));
    chk("overlap_awvalid", 64'(axi_awvalid), 64'(1));
    read_burst(1, 32'h3000_0000, 1, -1, -1, w);
    chk("overlap_ar_now", 64'(w), 64'(0));
    write_burst(32'h2000_0040, 1, 1);

    // Reset asserted during the 4th beat of a read burst.
    ic_req = 1;
    ic_addr = $urandom;
    a = line_of(ic_addr);
    exp_last_dc = model_pick(ic_req, dc_req);
    read_burst(0, a, 0, -1, 3, w);
    reset = 1;
    #1;
    check_zero("reset_midburst");
    axi_rvalid = 0;
    axi_rlast = 0;
    axi_rdata = '0;
    repeat (2) tick();
    reset = 0;
    exp_last_dc = 0;
    settle();
    read_burst(0, a, 1, -1, -1, w);
    chk("post_reset_latency", 64'(w), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
